timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter.sv | 66 ++++++
 tb/tb_timer_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Delay timer for a serial-load / count-down control FSM.
// A 4-bit delay value is shifted in MSB first, then counted down one unit
// every TICKS cycles; done_counting flags the final cycle of the
// (delay+1)*TICKS window and stays high while counting is held.
module timer_counter #(
    parameter int unsigned TICKS  = 1000,
    parameter int unsigned TICK_W = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data,
    input  logic       shift_ena,
    input  logic       counting,
    output logic       done_counting,
    output logic [3:0] count
);

    localparam logic [TICK_W-1:0] TickReload = TICK_W'(TICKS - 1);

    logic [3:0]        r_delay;
    logic [TICK_W-1:0] r_tick;
    logic [3:0]        w_delay_next;
    logic [TICK_W-1:0] w_tick_next;
    logic              w_tick_zero;
    logic              w_delay_zero;
    logic              w_done;

    assign w_tick_zero  = (r_tick == '0);
    assign w_delay_zero = (r_delay == 4'd0);
    // Reset forces tick to a non-zero value, so done is already low in reset;
    // the explicit gate keeps the output clean whatever counting does.
    assign w_done       = reset & counting & w_delay_zero & w_tick_zero;

    // Next-state: shift wins over counting; count stops once done is reached.
    always_comb begin
        w_delay_next = r_delay;
        w_tick_next  = r_tick;
        if (shift_ena) begin
            w_delay_next = {r_delay[2:0], data};
            w_tick_next  = TickReload;
        end else if (counting && !w_done) begin
            if (w_tick_zero) begin
                // Unit boundary; delay is non-zero here because done is low.
                w_tick_next  = TickReload;
                w_delay_next = r_delay - 4'd1;
            end else begin
                w_tick_next  = r_tick - TICK_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_delay <= 4'd0;
            r_tick  <= TickReload;
        end else begin
            r_delay <= w_delay_next;
            r_tick  <= w_tick_next;
        end
    end

    assign done_counting = w_done;
    assign count         = r_delay;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: the driver pushes the expected outputs
// for each checked cycle, the monitor samples 1ns before the rising edge.
module tb_timer_counter;

    logic       clk;
    logic       reset;
    logic       data;
    logic       shift_ena;
    logic       counting;
    logic       done_s;
    logic [3:0] count_s;
    logic       done_d;
    logic [3:0] count_d;

    typedef struct {
        logic [3:0] cnt;
        logic       done;
        bit         inst;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    timer_counter #(
        .TICKS (4),
        .TICK_W(2)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .shift_ena    (shift_ena),
        .counting     (counting),
        .done_counting(done_s),
        .count        (count_s)
    );

    timer_counter u_dut_def (
        .clk          (clk),
        .reset        (reset),
        .data         (data),
        .shift_ena    (shift_ena),
        .counting     (counting),
        .done_counting(done_d),
        .count        (count_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input bit inst, input logic [3:0] ec, input logic ed,
                            input string tag);
        exp_t e;
        e.cnt  = ec;
        e.done = ed;
        e.inst = inst;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    // One cycle: drive inputs just after the falling edge, optionally expect outputs.
    task automatic step(input logic sh, input logic d, input logic cn, input bit chk,
                        input bit inst, input logic [3:0] ec, input logic ed,
                        input string tag);
        @(negedge clk);
        #1;
        reset     = 1'b1;
        shift_ena = sh;
        data      = d;
        counting  = cn;
        if (chk) push_exp(inst, ec, ed, tag);
    endtask

    task automatic load(input logic [3:0] val);
        for (int i = 3; i >= 0; i--) step(1'b1, val[i], 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "");
    endtask

    // Counting cycles k_lo..k_hi for delay dv with t ticks per unit.
    task automatic run(input int dv, input int t, input bit inst, input int k_lo,
                       input int k_hi, input string tag);
        int         u;
        logic [3:0] ec;
        logic       ed;
        bit         chk;
        for (int k = k_lo; k <= k_hi; k++) begin
            u   = (k - 1) / t;
            ec  = (u <= dv) ? 4'(dv - u) : 4'd0;
            ed  = (k >= (dv + 1) * t);
            chk = !inst || k == 1 || k == 1000 || k == 1001 || k == 1999 || k == 2000 ||
                  k == 2001;
            step(1'b0, 1'b0, 1'b1, chk, inst, ec, ed, $sformatf("%s_k%0d", tag, k));
        end
    endtask

    // Monitor: compare one scoreboard entry per cycle, just before the rising edge.
    initial begin
        exp_t       e;
        logic [3:0] oc;
        logic       od;
        forever begin
            @(negedge clk);
            #4;
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                oc = e.inst ? count_d : count_s;
                od = e.inst ? done_d : done_s;
                n_tests++;
                if (oc !== e.cnt || od !== e.done) begin
                    n_fail++;
                    $display("FAIL %s: got count=%0d done=%b, expected count=%0d done=%b",
                             e.tag, oc, od, e.cnt, e.done);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b0;
        data      = 1'b0;
        shift_ena = 1'b0;
        counting  = 1'b1;

        // Reset state, counting ignored.
        @(negedge clk); #1; push_exp(1'b0, 4'd0, 1'b0, "reset_small");
        @(negedge clk); #1; push_exp(1'b1, 4'd0, 1'b0, "reset_default");

        // Load 1,0,1,0 -> 4'b1010.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, "load_c1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0, "load_c2");
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2,  1'b0, "load_c3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5,  1'b0, "load_c4");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, "load_done");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10, 1'b0, "idle_hold");

        // d=2: done first in cycle 12, then held.
        load(4'd2);
        run(2, 4, 1'b0, 1, 14, "d2");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "idle_done_low");

        // Boundaries d=0 and d=15, no wrap after zero.
        load(4'd0);
        run(0, 4, 1'b0, 1, 6, "d0");
        load(4'd15);
        run(15, 4, 1'b0, 1, 67, "d15");

        // Shift with counting high: shift only (state is delay 0, tick 0 here).
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, "prio_c1");
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "prio_c2");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, "prio_c3");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, "prio_c4");
        run(3, 4, 1'b0, 1, 17, "prio_d3");

        // Pause for 3 cycles mid-count.
        load(4'd1);
        run(1, 4, 1'b0, 1, 3, "pause_pre");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, $sformatf("pause_p%0d", i));
        run(1, 4, 1'b0, 4, 9, "pause_post");

        // Async reset mid-cycle during d=5 count, then restart from reset values.
        load(4'd5);
        run(5, 4, 1'b0, 1, 6, "ar_pre");
        @(negedge clk); #1;
        counting = 1'b1;
        #1 reset = 1'b0;
        push_exp(1'b0, 4'd0, 1'b0, "ar_async");
        run(0, 4, 1'b0, 1, 5, "ar_post");

        // Default TICKS=1000, d=1: done at cycle 2000, held after.
        load(4'd1);
        run(1, 1000, 1'b1, 1, 2001, "def_d1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "");

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
